// File: rtl/conv1d_2nd_ram_sequencer_pkg.sv
// Shared definitions for the layer-2 data RAM sequencer.
// Holds the RAM geometry (banks, positions, filter sweeps), the counter
// widths derived from it, the terminal count values and the FSM state type.
package conv1d_2nd_ram_sequencer_pkg;

  localparam int N_DEPTH   = 8;
  localparam int N_WIDTH   = 256;
  localparam int N_FILTERS = 16;

  localparam int DEPTH_W = $clog2(N_DEPTH);
  localparam int WIDTH_W = $clog2(N_WIDTH);
  localparam int FILT_W  = $clog2(N_FILTERS);

  // Terminal counts of each loop level
  localparam logic [DEPTH_W-1:0] D_MAX = DEPTH_W'(N_DEPTH - 1);
  localparam logic [WIDTH_W-1:0] W_MAX = WIDTH_W'(N_WIDTH - 1);
  localparam logic [FILT_W-1:0]  F_MAX = FILT_W'(N_FILTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/conv1d_2nd_ram_sequencer_nested_counter3.sv
// nested_counter3: three-level d (inner) / w / f (outer) counter.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr         : synchronous clear of all three levels (wins over adv)
//   adv         : step the count by one
//   f_en        : when low the outer level is frozen and the count is
//                 treated as a two-level d/w counter
//   d, w, f     : current count
//   d_wrap      : d is at its terminal value
//   w_wrap      : d and w are both at their terminal values
//   last        : the count is the final one of the enabled levels
module nested_counter3
  import conv1d_2nd_ram_sequencer_pkg::*;
#(
  parameter logic [DEPTH_W-1:0] D_LAST = D_MAX,
  parameter logic [WIDTH_W-1:0] W_LAST = W_MAX,
  parameter logic [FILT_W-1:0]  F_LAST = F_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  input  logic               f_en,
  output logic [DEPTH_W-1:0] d,
  output logic [WIDTH_W-1:0] w,
  output logic [FILT_W-1:0]  f,
  output logic               d_wrap,
  output logic               w_wrap,
  output logic               last
);

  logic [DEPTH_W-1:0] d_q, d_d;
  logic [WIDTH_W-1:0] w_q, w_d;
  logic [FILT_W-1:0]  f_q, f_d;

  always_comb begin
    d_wrap = (d_q == D_LAST);
    w_wrap = d_wrap && (w_q == W_LAST);
    last   = w_wrap && (!f_en || (f_q == F_LAST));
  end

  always_comb begin
    d_d = d_q;
    w_d = w_q;
    f_d = f_q;
    if (clr) begin
      d_d = '0;
      w_d = '0;
      f_d = '0;
    end else if (adv) begin
      if (d_wrap) begin
        d_d = '0;
        if (w_q == W_LAST) begin
          w_d = '0;
          if (f_en) begin
            f_d = (f_q == F_LAST) ? '0 : f_q + 1'b1;
          end
        end else begin
          w_d = w_q + 1'b1;
        end
      end else begin
        d_d = d_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
      w_q <= '0;
      f_q <= '0;
    end else begin
      d_q <= d_d;
      w_q <= w_d;
      f_q <= f_d;
    end
  end

  assign d = d_q;
  assign w = w_q;
  assign f = f_q;

endmodule

// File: rtl/conv1d_2nd_ram_sequencer.sv
// conv1d_2nd_ram_sequencer: loads layer-1 results into the 8-bank x 256
// position data RAM, then sweeps it once per layer-2 filter, one 3-tap
// window (w-1, w, w+1 of one bank) per read.
// Ports:
//   clk, rst            : clock (RAM samples on negedge), async active-high reset
//   start               : one-cycle pulse, only honoured in IDLE
//   wr_valid/ready/data : layer-1 word stream, transfer on valid & ready
//   ram_write_*         : registered RAM write port (enable, bank, position, data)
//   ram_read_*          : RAM read port (enable, bank, position)
//   tap_valid/ready     : tap handshake towards the MAC, transfer on valid & ready
//   tap_filter/width    : tags of the current tap
//   tap_first/last      : tap is bank 0 / bank N_DEPTH-1
//   busy, done          : not idle / one-cycle end-of-run pulse
// Handshakes: a transfer happens on every rising clk edge where valid and
// ready are both high; valid never waits on ready, and a presented tap holds
// its tags and address until it is transferred.
module conv1d_2nd_ram_sequencer
  import conv1d_2nd_ram_sequencer_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wr_valid,
  input  logic [BIT_WIDTH-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 ram_write_enable,
  output logic [DEPTH_W-1:0]   ram_write_depth,
  output logic [WIDTH_W-1:0]   ram_write_width,
  output logic [BIT_WIDTH-1:0] ram_data_in,
  output logic                 ram_read_enable,
  output logic [DEPTH_W-1:0]   ram_read_depth,
  output logic [WIDTH_W-1:0]   ram_read_width,
  output logic                 tap_valid,
  input  logic                 tap_ready,
  output logic [FILT_W-1:0]    tap_filter,
  output logic [WIDTH_W-1:0]   tap_width,
  output logic                 tap_first,
  output logic                 tap_last,
  output logic                 busy,
  output logic                 done
);

  state_t state_q, state_d;

  logic                 wr_en_q, wr_en_d;
  logic [DEPTH_W-1:0]   wr_depth_q, wr_depth_d;
  logic [WIDTH_W-1:0]   wr_width_q, wr_width_d;
  logic [BIT_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                 tap_valid_q, tap_valid_d;
  logic [FILT_W-1:0]    tap_f_q, tap_f_d;
  logic [WIDTH_W-1:0]   tap_w_q, tap_w_d;
  logic [DEPTH_W-1:0]   tap_d_q, tap_d_d;
  logic                 issued_all_q, issued_all_d;

  logic [DEPTH_W-1:0] cnt_d;
  logic [WIDTH_W-1:0] cnt_w;
  logic [FILT_W-1:0]  cnt_f;
  logic               cnt_d_wrap, cnt_w_wrap, cnt_last;
  logic               cnt_clr, cnt_adv, cnt_f_en;

  logic in_load, in_comp, wr_accept, rd_active, tap_free, issue, final_tap;

  // One counter serves both phases: d/w for the load order, f/w/d for the
  // sweep. It always holds the next address to write or to issue.
  nested_counter3 u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .adv    (cnt_adv),
    .f_en   (cnt_f_en),
    .d      (cnt_d),
    .w      (cnt_w),
    .f      (cnt_f),
    .d_wrap (cnt_d_wrap),
    .w_wrap (cnt_w_wrap),
    .last   (cnt_last)
  );

  always_comb begin
    in_load   = (state_q == ST_LOAD);
    in_comp   = (state_q == ST_COMPUTE);
    wr_accept = in_load && wr_valid;
    // The last registered write is still on the RAM port during the first
    // COMPUTE cycle, so reads start one cycle later to keep the enables apart.
    rd_active = in_comp && !wr_en_q;
    tap_free  = !tap_valid_q || tap_ready;
    issue     = rd_active && tap_free && !issued_all_q;
    final_tap = tap_valid_q && tap_ready && (tap_f_q == F_MAX)
                && (tap_w_q == W_MAX) && (tap_d_q == D_MAX);

    cnt_f_en = in_comp;
    cnt_adv  = wr_accept || issue;
    cnt_clr  = ((state_q == ST_IDLE) && start) || (wr_accept && cnt_last);
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD;
      ST_LOAD:    if (wr_accept && cnt_last) state_d = ST_COMPUTE;
      ST_COMPUTE: if (final_tap) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Write port and tap pipeline
  always_comb begin
    wr_en_d    = wr_accept;
    wr_depth_d = wr_depth_q;
    wr_width_d = wr_width_q;
    wr_data_d  = wr_data_q;
    if (wr_accept) begin
      wr_depth_d = cnt_d;
      wr_width_d = cnt_w;
      wr_data_d  = wr_data;
    end

    tap_valid_d = tap_valid_q;
    tap_f_d     = tap_f_q;
    tap_w_d     = tap_w_q;
    tap_d_d     = tap_d_q;
    if (!in_comp) begin
      tap_valid_d = 1'b0;
    end else if (tap_free) begin
      tap_valid_d = issue;
      if (issue) begin
        tap_f_d = cnt_f;
        tap_w_d = cnt_w;
        tap_d_d = cnt_d;
      end
    end

    issued_all_d = issued_all_q;
    if (!in_comp) begin
      issued_all_d = 1'b0;
    end else if (issue && cnt_last) begin
      issued_all_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_en_q      <= 1'b0;
      wr_depth_q   <= '0;
      wr_width_q   <= '0;
      wr_data_q    <= '0;
      tap_valid_q  <= 1'b0;
      tap_f_q      <= '0;
      tap_w_q      <= '0;
      tap_d_q      <= '0;
      issued_all_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_depth_q   <= wr_depth_d;
      wr_width_q   <= wr_width_d;
      wr_data_q    <= wr_data_d;
      tap_valid_q  <= tap_valid_d;
      tap_f_q      <= tap_f_d;
      tap_w_q      <= tap_w_d;
      tap_d_q      <= tap_d_d;
      issued_all_q <= issued_all_d;
    end
  end

  // The read address must already point at the tap being stalled before the
  // RAM's negedge sample, so it selects on the live tap_ready: a free slot
  // issues the counter, a stalled tap re-reads its own address.
  always_comb begin
    ram_read_enable = rd_active;
    ram_read_depth  = '0;
    ram_read_width  = '0;
    if (rd_active) begin
      ram_read_depth = issue ? cnt_d : tap_d_q;
      ram_read_width = issue ? cnt_w : tap_w_q;
    end
  end

  assign wr_ready         = in_load;
  assign ram_write_enable = wr_en_q;
  assign ram_write_depth  = wr_depth_q;
  assign ram_write_width  = wr_width_q;
  assign ram_data_in      = wr_data_q;

  assign tap_valid  = tap_valid_q;
  assign tap_filter = tap_f_q;
  assign tap_width  = tap_w_q;
  assign tap_first  = tap_valid_q && (tap_d_q == '0);
  assign tap_last   = tap_valid_q && (tap_d_q == D_MAX);

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv1d_2nd_ram_sequencer.sv
// Self-checking bench for conv1d_2nd_ram_sequencer with a negedge RAM model.
module tb_conv1d_2nd_ram_sequencer;

  localparam int N_TAPS = 16 * 256 * 8;

  typedef struct packed {
    logic [3:0]  f;
    logic [7:0]  w;
    logic [2:0]  d;
    logic        first;
    logic        last;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
  } tap_t;
  localparam int TAP_W = $bits(tap_t);

  typedef struct {
    int   idx;
    tap_t exp;
  } tv_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, wr_valid, tap_ready;
  logic [15:0] wr_data;
  logic        wr_ready, ram_write_enable, ram_read_enable;
  logic [2:0]  ram_write_depth, ram_read_depth;
  logic [7:0]  ram_write_width, ram_read_width, tap_width;
  logic [15:0] ram_data_in;
  logic        tap_valid, tap_first, tap_last, busy, done;
  logic [3:0]  tap_filter;

  conv1d_2nd_ram_sequencer #(.BIT_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .wr_valid         (wr_valid),
    .wr_data          (wr_data),
    .wr_ready         (wr_ready),
    .ram_write_enable (ram_write_enable),
    .ram_write_depth  (ram_write_depth),
    .ram_write_width  (ram_write_width),
    .ram_data_in      (ram_data_in),
    .ram_read_enable  (ram_read_enable),
    .ram_read_depth   (ram_read_depth),
    .ram_read_width   (ram_read_width),
    .tap_valid        (tap_valid),
    .tap_ready        (tap_ready),
    .tap_filter       (tap_filter),
    .tap_width        (tap_width),
    .tap_first        (tap_first),
    .tap_last         (tap_last),
    .busy             (busy),
    .done             (done)
  );

  wire logic [57:0] all_outs = {wr_ready, ram_write_enable, ram_write_depth,
    ram_write_width, ram_data_in, ram_read_enable, ram_read_depth,
    ram_read_width, tap_valid, tap_filter, tap_width, tap_first, tap_last,
    busy, done};

  // RAM model: write and read both sampled on negedge, 0 padding at edges
  logic [15:0] mem [0:7][0:255];
  logic [15:0] dout0, dout1, dout2;
  int          wr_count = 0;
  int          conflict_cnt = 0;
  int          stall_err = 0;
  logic        prev_en = 1'b0;
  logic [2:0]  prev_d = '0;
  logic [7:0]  prev_w = '0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_write_enable) begin
      mem[ram_write_depth][ram_write_width] <= ram_data_in;
      wr_count <= wr_count + 1;
    end
    if ((ram_write_enable || wr_ready) && ram_read_enable)
      conflict_cnt <= conflict_cnt + 1;
    if (ram_read_enable) begin
      dout0 <= (ram_read_width == 8'd0) ? 16'd0
               : mem[ram_read_depth][ram_read_width - 8'd1];
      dout1 <= mem[ram_read_depth][ram_read_width];
      dout2 <= (ram_read_width == 8'd255) ? 16'd0
               : mem[ram_read_depth][ram_read_width + 8'd1];
    end
    // a stalled tap must keep the RAM pointed at the same address
    if (tap_valid && !tap_ready && ram_read_enable &&
        (!prev_en || prev_d != ram_read_depth || prev_w != ram_read_width))
      stall_err <= stall_err + 1;
    prev_en <= ram_read_enable;
    prev_d  <= ram_read_depth;
    prev_w  <= ram_read_width;
  end

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [TAP_W-1:0] exp_q[$];
  logic [TAP_W-1:0] log_b [0:N_TAPS-1];
  int start_cyc, first_cyc;
  tv_t tv [9];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic tap_t mk_tap(int f, int w, int d, bit first, bit last,
                                  int a, int b, int c);
    tap_t t;
    t.f = 4'(f); t.w = 8'(w); t.d = 3'(d);
    t.first = first; t.last = last;
    t.d0 = 16'(a); t.d1 = 16'(b); t.d2 = 16'(c);
    return t;
  endfunction

  function automatic tv_t mk_tv(int idx, int f, int w, int d, bit first,
                                bit last, int a, int b, int c);
    tv_t v;
    v.idx = idx;
    v.exp = mk_tap(f, w, d, first, last, a, b, c);
    return v;
  endfunction

  // Reference: tap n sweeps f, w, d with d fastest; the word loaded k-th
  // sits at bank k%8, position k/8, so bank d position w holds 8w+d.
  function automatic tap_t exp_tap(int n);
    int f, w, d;
    f = n / 2048;
    w = (n / 8) % 256;
    d = n % 8;
    return mk_tap(f, w, d, d == 0, d == 7,
                  (w == 0) ? 0 : 8 * (w - 1) + d,
                  8 * w + d,
                  (w == 255) ? 0 : 8 * (w + 1) + d);
  endfunction

  // driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic do_load(input bit toggle, input bit poke, input string tag);
    int  k = 0;
    int  c = 0;
    int  base = wr_count;
    int  bad = 0;
    bit  acc;
    while (k < 2048 && c < 6000) begin
      @(negedge clk);
      wr_valid = toggle ? (c % 2 == 0) : 1'b1;
      wr_data  = 16'(k);
      start    = poke && (k == 1000);
      acc      = wr_valid && wr_ready;
      @(posedge clk);
      if (acc) k++;
      c++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_load_accepts"}, 64'(k), 64'd2048);
    check({tag, "_load_exit_ready_busy"}, {62'd0, wr_ready, busy}, 64'b01);
    #1;
    check({tag, "_load_writes"}, 64'(wr_count - base), 64'd2048);
    for (int d = 0; d < 8; d++)
      for (int w = 0; w < 256; w++)
        if (mem[d][w] !== 16'(8 * w + d)) bad++;
    check({tag, "_ram_contents_bad"}, 64'(bad), 64'd0);
  endtask

  task automatic do_compute(input int n_taps, input bit stall, input bit poke,
                            input bit vs_log, input bit to_log,
                            input string tag);
    int   n = 0;
    int   c = 0;
    int   bad = 0;
    bit   seen = 1'b0;
    bit   poked = 1'b0;
    tap_t got, want;
    exp_q.delete();
    for (int i = 0; i < n_taps; i++) exp_q.push_back(exp_tap(i));
    while (n < n_taps && c < 40000) begin
      @(posedge clk);
      #1;
      c++;
      start = 1'b0;
      if (poke && !poked && n == 10000) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (tap_valid && !seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      tap_ready = stall ? ($urandom_range(0, 7) != 0) : 1'b1;
      if (tap_valid && tap_ready) begin
        got = mk_tap(int'(tap_filter), int'(tap_width), int'(ram_read_depth),
                     tap_first, tap_last, int'(dout0), int'(dout1), int'(dout2));
        // depth tag is not a port: recover it from the model's expectation
        // only through the data and first/last flags, so zero it on both sides
        got.d = 3'd0;
        want = exp_q.pop_front();
        want.d = 3'd0;
        if (got !== want || (vs_log && (TAP_W'(got) !== log_b[n]))) begin
          if (bad == 0)
            $display("  %s first bad tap #%0d: got %h want %h", tag, n, got, want);
          bad++;
        end
        if (to_log) log_b[n] = got;
        n++;
      end
    end
    start = 1'b0;
    check({tag, "_taps_taken"}, 64'(n), 64'(n_taps));
    check({tag, "_tap_stream_bad"}, 64'(bad), 64'd0);
  endtask

  task automatic check_end(input string tag);
    check({tag, "_done_at_handshake"}, {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_busy_after"}, {62'd0, done, busy}, 64'b11);
    @(posedge clk);
    #1;
    check({tag, "_done_busy_idle"}, {62'd0, done, busy}, 64'b00);
    tap_ready = 1'b0;
  endtask

  initial begin
    // the depth field of a tap is carried by data values and first/last
    tv[0] = mk_tv(0,     0,  0,   0, 1, 0, 0,    0,    8);
    tv[1] = mk_tv(7,     0,  0,   7, 0, 1, 0,    7,    15);
    tv[2] = mk_tv(8,     0,  1,   0, 1, 0, 0,    8,    16);
    tv[3] = mk_tv(803,   0,  100, 3, 0, 0, 795,  803,  811);
    tv[4] = mk_tv(2040,  0,  255, 0, 1, 0, 2032, 2040, 0);
    tv[5] = mk_tv(2047,  0,  255, 7, 0, 1, 2039, 2047, 0);
    tv[6] = mk_tv(2048,  1,  0,   0, 1, 0, 0,    0,    8);
    tv[7] = mk_tv(16387, 8,  0,   3, 0, 0, 0,    3,    11);
    tv[8] = mk_tv(32767, 15, 255, 7, 0, 1, 2039, 2047, 0);

    rst = 1'b1;
    start = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    tap_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(all_outs), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Run A: constant load, partial sweep, asynchronous reset mid-COMPUTE
    pulse_start();
    do_load(1'b0, 1'b0, "A");
    do_compute(3 * 2048 + 100 * 8, 1'b0, 1'b0, 1'b0, 1'b0, "A");
    // rising edges from the one sampling start through the one raising tap_valid
    check("A_start_to_tap_latency", 64'(first_cyc - start_cyc + 1), 64'd2051);
    #2;
    rst = 1'b1;
    #1;
    check("A_reset_mid_outputs", 64'(all_outs), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tap_ready = 1'b0;

    // Run B: toggling wr_valid, full sweep without stalls
    pulse_start();
    do_load(1'b1, 1'b0, "B");
    do_compute(N_TAPS, 1'b0, 1'b0, 1'b0, 1'b1, "B");
    check_end("B");
    for (int i = 0; i < 9; i++) begin
      tap_t e;
      e = tv[i].exp;
      e.d = 3'd0;
      check($sformatf("tv_tap_%0d", tv[i].idx), 64'(log_b[tv[i].idx]),
            64'(TAP_W'(e)));
    end

    // Run C: random stalls, start pokes during LOAD and COMPUTE
    pulse_start();
    do_load(1'b0, 1'b1, "C");
    do_compute(N_TAPS, 1'b1, 1'b1, 1'b1, 1'b0, "C");
    check_end("C");

    check("stall_address_moved", 64'(stall_err), 64'd0);
    check("enable_conflicts", 64'(conflict_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
